// File: rtl/lif_pkg.sv
// Shared constants, FSM state type and saturation helper for the LIF array scheduler.
package lif_pkg;

  localparam int LEAK_NUM     = 112;
  localparam int LEAK_SHIFT   = 7;
  localparam int THR_UP_SHIFT = 3;
  localparam int THR_DN_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } sched_state_t;

  // Clamp a widened unsigned sum back into 8 bits.
  function automatic logic [7:0] sat255(input logic [9:0] x);
    return (x > 10'd255) ? 8'hFF : x[7:0];
  endfunction

endpackage

// File: rtl/lif_array_scheduler_if.sv
// Host current-injection bus plus spike event handshake towards the router.
// master: environment side (host + router); slave: the scheduler.
interface lif_array_scheduler_if #(
  parameter int IDX_W = 2
) ();

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_current;
  logic             spike_valid;
  logic [IDX_W-1:0] spike_idx;
  logic             spike_ready;

  modport master (
    output wr_en,
    output wr_idx,
    output wr_current,
    output spike_ready,
    input  spike_valid,
    input  spike_idx
  );

  modport slave (
    input  wr_en,
    input  wr_idx,
    input  wr_current,
    input  spike_ready,
    output spike_valid,
    output spike_idx
  );

endinterface

// File: rtl/lif_update_core.sv
// Combinational single-neuron LIF update: leak/integrate, fire, adaptive threshold.
// Optional refractory counter enabled by LIF_REFRACTORY_EN.
module lif_update_core
  import lif_pkg::*;
#(
  parameter logic [7:0] THR_MAX = 8'd220,
  parameter logic [7:0] THR_MIN = 8'd8
`ifdef LIF_REFRACTORY_EN
  ,
  parameter int REFR_STEPS = 2,
  parameter int REFR_W     = 2
`endif
) (
  input  logic [7:0]        state,
  input  logic [7:0]        thr,
  input  logic [7:0]        acc,
`ifdef LIF_REFRACTORY_EN
  input  logic [REFR_W-1:0] refr,
  output logic [REFR_W-1:0] refr_next,
`endif
  output logic              fire,
  output logic [7:0]        state_next,
  output logic [7:0]        thr_next
);

  logic [14:0] leak_prod;
  logic [7:0]  leaked;
  logic [7:0]  integ;
  logic [7:0]  thr_up;
  logic [7:0]  thr_dn;
  logic        in_refr;

  // Leak, integrate and threshold adaptation; fire resets the membrane.
  always_comb begin
    leak_prod = {7'd0, state} * 15'(LEAK_NUM);
    leaked    = 8'(leak_prod >> LEAK_SHIFT);
    integ     = sat255({2'd0, acc} + {2'd0, leaked});
    thr_up    = (thr < THR_MAX) ? sat255({2'd0, thr} + {2'd0, (thr >> THR_UP_SHIFT)}) : thr;
    thr_dn    = (thr > THR_MIN) ? (thr - (thr >> THR_DN_SHIFT)) : thr;
`ifdef LIF_REFRACTORY_EN
    in_refr   = (refr != '0);
    fire      = !in_refr && (state >= thr);
    refr_next = refr;
`else
    in_refr   = 1'b0;
    fire      = (state >= thr);
`endif
    if (fire) begin
      state_next = 8'd0;
      thr_next   = thr_up;
`ifdef LIF_REFRACTORY_EN
      refr_next  = REFR_W'(REFR_STEPS);
`endif
    end else begin
      state_next = in_refr ? 8'd0 : integ;
      thr_next   = thr_dn;
`ifdef LIF_REFRACTORY_EN
      if (in_refr) refr_next = refr - REFR_W'(1);
`endif
    end
  end

endmodule

// File: rtl/lif_array_scheduler.sv
// Time-multiplexed LIF array: register files, sweep FSM and spike handshake.
// Refractory counters are included when LIF_REFRACTORY_EN is defined.
module lif_array_scheduler
  import lif_pkg::*;
#(
  parameter int         N_NEURONS = 4,
  parameter int         IDX_W     = 2,
  parameter logic [7:0] THR_INIT  = 8'd100,
  parameter logic [7:0] THR_MAX   = 8'd220,
  parameter logic [7:0] THR_MIN   = 8'd8
`ifdef LIF_REFRACTORY_EN
  ,
  parameter int         REFR_STEPS = 2
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  lif_array_scheduler_if.slave bus
);

  sched_state_t     fsm_q, fsm_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             upd_en;
  logic             last;

  logic [7:0] state_q [N_NEURONS];
  logic [7:0] thr_q   [N_NEURONS];
  logic [7:0] acc_q   [N_NEURONS];

  logic [7:0] cur_state, cur_thr, cur_acc;
  logic       core_fire;
  logic [7:0] core_state, core_thr;

`ifdef LIF_REFRACTORY_EN
  localparam int REFR_W = $clog2(REFR_STEPS + 1);
  logic [REFR_W-1:0] refr_q [N_NEURONS];
  logic [REFR_W-1:0] cur_refr, core_refr;
`endif

  // Select the neuron currently being swept.
  always_comb begin
    cur_state = state_q[idx_q];
    cur_thr   = thr_q[idx_q];
    cur_acc   = acc_q[idx_q];
`ifdef LIF_REFRACTORY_EN
    cur_refr  = refr_q[idx_q];
`endif
  end

  lif_update_core #(
    .THR_MAX    (THR_MAX),
    .THR_MIN    (THR_MIN)
`ifdef LIF_REFRACTORY_EN
    ,
    .REFR_STEPS (REFR_STEPS),
    .REFR_W     (REFR_W)
`endif
  ) u_core (
    .state      (cur_state),
    .thr        (cur_thr),
    .acc        (cur_acc),
`ifdef LIF_REFRACTORY_EN
    .refr       (cur_refr),
    .refr_next  (core_refr),
`endif
    .fire       (core_fire),
    .state_next (core_state),
    .thr_next   (core_thr)
  );

  assign last = (idx_q == IDX_W'(N_NEURONS - 1));

  // Next-state logic: one neuron per SCAN cycle, stall in EMIT until accepted.
  always_comb begin
    fsm_d  = fsm_q;
    idx_d  = idx_q;
    upd_en = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (step) begin
          fsm_d = SCAN;
          idx_d = '0;
        end
      end
      SCAN: begin
        upd_en = 1'b1;
        if (core_fire) begin
          fsm_d = EMIT;
        end else if (last) begin
          fsm_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      EMIT: begin
        if (bus.spike_ready) begin
          if (last) begin
            fsm_d = DONE;
          end else begin
            fsm_d = SCAN;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        fsm_d = IDLE;
        idx_d = '0;
      end
      default: begin
        fsm_d = IDLE;
        idx_d = '0;
      end
    endcase
  end

  // FSM state, sweep index and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      idx_q   <= '0;
      overrun <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
      if (step && (fsm_q != IDLE)) overrun <= 1'b1;
    end
  end

  // Per-neuron register files; a same-cycle write to the swept neuron seeds the next step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= 8'd0;
        thr_q[i]   <= THR_INIT;
        acc_q[i]   <= 8'd0;
`ifdef LIF_REFRACTORY_EN
        refr_q[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (upd_en && (idx_q == IDX_W'(i))) begin
          state_q[i] <= core_state;
          thr_q[i]   <= core_thr;
`ifdef LIF_REFRACTORY_EN
          refr_q[i]  <= core_refr;
`endif
          acc_q[i]   <= (bus.wr_en && (bus.wr_idx == IDX_W'(i))) ? bus.wr_current : 8'd0;
        end else if (bus.wr_en && (bus.wr_idx == IDX_W'(i))) begin
          acc_q[i]   <= sat255({2'd0, acc_q[i]} + {2'd0, bus.wr_current});
        end
      end
    end
  end

  assign busy            = (fsm_q != IDLE);
  assign done            = (fsm_q == DONE);
  assign bus.spike_valid = (fsm_q == EMIT);
  assign bus.spike_idx   = idx_q;

endmodule

// File: tb/tb_lif_array_scheduler.sv
// Scoreboard bench for lif_array_scheduler: expected spike/done events are queued
// when a sweep is launched and consumed by an independent negedge monitor.
module tb_lif_array_scheduler;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int DONE_TAG = 99;

  logic clk = 1'b0;
  logic rst_n;
  logic step;
  logic busy, done, overrun;

  lif_array_scheduler_if #(.IDX_W(IDX_W)) bus ();

  lif_array_scheduler #(
    .N_NEURONS (N),
    .IDX_W     (IDX_W)
`ifdef LIF_REFRACTORY_EN
    ,
    .REFR_STEPS(2)
`endif
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (step),
    .busy    (busy),
    .done    (done),
    .overrun (overrun),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int t0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consume expected events on handshakes and done pulses; check hold stability.
  logic             prev_hold = 1'b0;
  logic [IDX_W-1:0] prev_idx  = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", int'(bus.spike_valid), 1);
          check("hold_idx", int'(bus.spike_idx), int'(prev_idx));
        end
        if (bus.spike_valid && bus.spike_ready) begin
          if (exp_q.size() == 0) check("spike_unexpected", int'(bus.spike_idx), -1);
          else check("spike_idx", int'(bus.spike_idx), exp_q.pop_front());
        end
        if (done) begin
          if (exp_q.size() == 0) check("done_unexpected", DONE_TAG, -1);
          else check("done_event", DONE_TAG, exp_q.pop_front());
        end
        prev_hold = bus.spike_valid && !bus.spike_ready;
        prev_idx  = bus.spike_idx;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wr(input int i, input int v);
    bus.wr_en      = 1'b1;
    bus.wr_idx     = IDX_W'(i);
    bus.wr_current = 8'(v);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic start_step();
    step = 1'b1;
    t0   = cyc;
    @(posedge clk);
    #1 step = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int k = 0;
    while (!done && k < 400) begin
      @(posedge clk);
      #1 k++;
    end
    if (!done) check({name, "_timeout"}, int'(done), 1);
    else if (exp_lat > 0) check({name, "_latency"}, cyc - t0 + 1, exp_lat);
    @(posedge clk);
    #1 check({name, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!bus.spike_valid && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    check({name, "_valid"}, int'(bus.spike_valid), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    step           = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_idx     = '0;
    bus.wr_current = 8'd0;
    bus.spike_ready = 1'b1;
    do_reset();

    // Reset values
    check("rst_spike_valid", int'(bus.spike_valid), 0);
    check("rst_spike_idx", int'(bus.spike_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_thr0", int'(dut.thr_q[0]), 100);
    check("rst_acc0", int'(dut.acc_q[0]), 0);

    // 1: empty sweep, thresholds decay 100 -> 94
    exp_q.push_back(DONE_TAG);
    start_step();
    check("t1_busy", int'(busy), 1);
    wait_done("t1", N + 2);
    for (int i = 0; i < N; i++) begin
      check($sformatf("t1_thr%0d", i), int'(dut.thr_q[i]), 94);
      check($sformatf("t1_state%0d", i), int'(dut.state_q[i]), 0);
    end

    // 2: inject 120 into n1, integrate then fire on the next sweep
    do_reset();
    wr(1, 120);
    exp_q.push_back(DONE_TAG);
    start_step();
    wait_done("t2a", N + 2);
    check("t2a_state1", int'(dut.state_q[1]), 120);
    check("t2a_thr1", int'(dut.thr_q[1]), 94);
    exp_q.push_back(1);
    exp_q.push_back(DONE_TAG);
    start_step();
    wait_done("t2b", N + 3);
    check("t2b_state1", int'(dut.state_q[1]), 0);
    check("t2b_thr1", int'(dut.thr_q[1]), 105);
    check("t2b_thr0", int'(dut.thr_q[0]), 89);

    // 3: n0 and n2 fire with the router stalled for 5 cycles on the first event
    do_reset();
    wr(0, 200);
    wr(2, 200);
    exp_q.push_back(DONE_TAG);
    start_step();
    wait_done("t3a", N + 2);
    bus.spike_ready = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(2);
    exp_q.push_back(DONE_TAG);
    start_step();
    wait_valid("t3");
    repeat (5) begin
      @(posedge clk);
      #1 check("t3_stall_idx", int'(bus.spike_idx), 0);
      check("t3_stall_done", int'(done), 0);
    end
    bus.spike_ready = 1'b1;
    wait_done("t3b", 0);
    check("t3_state0", int'(dut.state_q[0]), 0);
    check("t3_thr0", int'(dut.thr_q[0]), 105);
    check("t3_thr2", int'(dut.thr_q[2]), 105);
    check("t3_thr1", int'(dut.thr_q[1]), 89);

    // 4: write to n3 in its update cycle lands in the next sweep; saturating accumulate
    do_reset();
    exp_q.push_back(DONE_TAG);
    start_step();
    repeat (3) @(posedge clk);
    #1 wr(3, 50);
    wait_done("t4a", 0);
    check("t4a_acc3", int'(dut.acc_q[3]), 50);
    check("t4a_state3", int'(dut.state_q[3]), 0);
    exp_q.push_back(DONE_TAG);
    start_step();
    wait_done("t4b", N + 2);
    check("t4b_state3", int'(dut.state_q[3]), 50);
    check("t4b_acc3", int'(dut.acc_q[3]), 0);
    wr(2, 200);
    wr(2, 200);
    check("t4_acc2_sat", int'(dut.acc_q[2]), 255);
    exp_q.push_back(DONE_TAG);
    start_step();
    wait_done("t4c", N + 2);
    check("t4c_state2", int'(dut.state_q[2]), 255);

    // 5: step while busy sets sticky overrun; reset mid-EMIT
    do_reset();
    check("t5_overrun_init", int'(overrun), 0);
    exp_q.push_back(DONE_TAG);
    start_step();
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    check("t5_overrun_set", int'(overrun), 1);
    wait_done("t5a", N + 2);
    repeat (3) @(posedge clk);
    #1 check("t5_overrun_sticky", int'(overrun), 1);
    wr(0, 200);
    exp_q.push_back(DONE_TAG);
    start_step();
    wait_done("t5b", N + 2);
    bus.spike_ready = 1'b0;
    start_step();
    wait_valid("t5");
    check("t5_emit_idx", int'(bus.spike_idx), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check("t5_rst_valid", int'(bus.spike_valid), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_overrun", int'(overrun), 0);
    check("t5_rst_thr0", int'(dut.thr_q[0]), 100);
    check("t5_rst_state0", int'(dut.state_q[0]), 0);
    check("t5_rst_idx", int'(bus.spike_idx), 0);
    rst_n = 1'b1;
    bus.spike_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("t5_idle_valid", int'(bus.spike_valid), 0);

`ifdef LIF_REFRACTORY_EN
    // 6: refractory holds state at 0 for two sweeps after a spike
    do_reset();
    wr(0, 200);
    exp_q.push_back(DONE_TAG);
    start_step();
    wait_done("t6a", N + 2);
    exp_q.push_back(0);
    exp_q.push_back(DONE_TAG);
    start_step();
    wait_done("t6b", N + 3);
    for (int s = 0; s < 2; s++) begin
      wr(0, 255);
      exp_q.push_back(DONE_TAG);
      start_step();
      wait_done("t6r", N + 2);
      check($sformatf("t6_refr_state_%0d", s), int'(dut.state_q[0]), 0);
      check($sformatf("t6_refr_acc_%0d", s), int'(dut.acc_q[0]), 0);
    end
    wr(0, 255);
    exp_q.push_back(DONE_TAG);
    start_step();
    wait_done("t6c", N + 2);
    check("t6_integrate", int'(dut.state_q[0]), 255);
`endif

    repeat (2) @(posedge clk);
    #1 check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
